// File: rtl/gs_pkg.sv
// Shared GS core definitions: reset PC, NOP encoding, fetch buffer entry and fetch FSM states.
package gs_pkg;

    localparam logic [31:0] GS_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] GS_INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [1:0] FETCH_IDLE  = 2'd0;
    localparam logic [1:0] FETCH_RUN   = 2'd1;
    localparam logic [1:0] FETCH_DRAIN = 2'd2;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/gs_fetch_fifo.sv
// Synchronous instruction buffer for gs_fetch; DEPTH must be a power of two so pointers wrap naturally.
module gs_fetch_fifo
    import gs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    push_into_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && !flush && full && !do_pop));

endmodule

// File: rtl/gs_fetch.sv
// Instruction fetch stage feeding GS_Decoder: PC/credit/drop tracking around a small FIFO.
// Optional same-cycle response bypass when built with GS_FETCH_BYPASS_EN.
module gs_fetch
    import gs_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = GS_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   out_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          full;
    logic          empty;
    fetch_entry_t  head;
    fetch_entry_t  rsp_entry;
    logic          req_hs;
    logic          rsp_keep;
    logic          bypass;
    logic          out_fire;
    logic          fifo_push;
    logic          fifo_pop;

    // Buffered words plus requests in flight may never exceed the buffer size.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !redirect_valid && (state != FETCH_IDLE)
                            && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign rsp_keep  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign rsp_entry = '{instr: imem_rsp_data};

`ifdef GS_FETCH_BYPASS_EN
    assign bypass = rsp_keep && empty;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = !empty || bypass;
    assign instr_o     = !empty ? head.instr : (bypass ? imem_rsp_data : 32'h0);
    assign pc_o        = out_pc;

    assign out_fire  = instr_valid && instr_ready && !redirect_valid;
    assign fifo_pop  = out_fire && !empty;
    assign fifo_push = rsp_keep && !(bypass && instr_ready);

    gs_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // On redirect every request still in flight is stale, so they all become drops.
    always_comb begin
        outstanding_next = outstanding + CW'(req_hs) - CW'(imem_rsp_valid);
        drop_next        = drop_cnt;
        if (redirect_valid)
            drop_next = outstanding_next;
        else if (imem_rsp_valid && (drop_cnt != '0))
            drop_next = drop_cnt - 1'b1;
        state_next = (drop_next != '0) ? FETCH_DRAIN : FETCH_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH_IDLE;
            fetch_pc    <= RESET_PC;
            out_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
                out_pc   <= word_align(redirect_pc);
            end else begin
                if (req_hs)   fetch_pc <= fetch_pc + 32'd4;
                if (out_fire) out_pc   <= out_pc + 32'd4;
            end
        end
    end

    logic unused_full;
    assign unused_full = full;

endmodule
